dual_issue_ctrl: RTL and testbench
==================================

# dual_issue_ctrl

Issue controller for the dual-issue decode stage. It sits between the two-lane decoder and the execute stage and decides each cycle whether to issue lane 1, lane 2, both or neither. A per-register scoreboard tracks multi-cycle producers (loads, multiplies). The block splits a decoded pair across two cycles when the two instructions cannot issue together, and drives the decode-stage `stall` so that the fetch packet is held while the pair drains.

## Interface
- `LOAD_BUBBLES`, default 1: bubble cycles between a load issuing and its first consumer issuing (range 1..3).
- `MUL_BUBBLES`, default 2: bubble cycles between mul.w issuing and its first consumer issuing (range 1..3).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in1_valid`, `in2_valid` in 1: decoded lane valids. Not masked by `stall_o`; must not depend combinationally on `stall_o`.
- `in1_src1`, `in1_src2`, `in2_src1`, `in2_src2` in 5: register read addresses.
- `in1_dest`, `in2_dest` in 5: destination register.
- `in1_gr_we`, `in2_gr_we` in 1: register write enable.
- `in1_class`, `in2_class` in 2: 0 ALU, 1 MEM, 2 MUL, 3 BR.
- `ex_flush` in 1: mispredict flush from execute; kills all younger work.
- `issue1_o`, `issue2_o` out 1: lane issues to execute this cycle.
- `stall_o` out 1: decode stage holds its packet register.

## Operation
- **State machine.** Two states: `PAIR` and `SECOND`.
  - In `PAIR`, lane 1 is the oldest instruction.
  - In `SECOND`, lane 1 has already issued and only lane 2 is pending.
- **Hazard rule (`hz(x)`).** An instruction has a hazard if either of its sources is nonzero and that register's scoreboard count is nonzero. Register r0 never hazards.
- **Pair rule.** Lane 2 may join lane 1 only if all of the following hold:
  - `!hz(in2)`.
  - Neither lane-2 source equals `in1_dest`, when `in1_gr_we` is set and `in1_dest` is not 0.
  - The two lanes are not both MEM.
  - The two lanes are not both MUL.
  - `in1_class` is not BR.
- **`PAIR` behaviour:**
  - `in1_valid` and `hz(in1)`: no issue, `stall_o`=1.
  - `in1_valid`, `!hz(in1)`, and lane 2 invalid or pairable: issue the valid lanes, `stall_o`=0.
  - `in1_valid`, `!hz(in1)`, `in2_valid`, and not pairable: `issue1_o`=1, `stall_o`=1, go to `SECOND`.
  - `!in1_valid`: lane 2 is evaluated alone. `issue2_o` = `in2_valid & !hz(in2)`, and `stall_o` = `in2_valid & hz(in2)`.
- **`SECOND` behaviour:**
  - `!hz(in2)`: `issue2_o`=1, `stall_o`=0, go to `PAIR`.
  - Otherwise: `stall_o`=1 and stay in `SECOND`.
  - `issue1_o` is always 0 in `SECOND`.
- **Flush.** `ex_flush`=1 forces `issue1_o`, `issue2_o` and `stall_o` to 0, and the next state is `PAIR`. The scoreboard is not cleared because older producers still complete; it keeps counting down.
- **Scoreboard.** One 2-bit counter per register; r0 is never written.
  - Every edge, each nonzero count decrements by 1.
  - An issued load (MEM with `gr_we`) loads `LOAD_BUBBLES` into its dest's counter.
  - An issued MUL loads `MUL_BUBBLES` into its dest's counter.
  - ALU and BR results are forwarded and create no entry.
- **Scoreboard conflicts:**
  - A load of a new value overrides the decrement on the same register.
  - If both lanes set the same register, lane 2's value wins.
  - A producer issued while `ex_flush`=1 does not exist, since nothing issues during a flush.

## Timing
- Issue and stall outputs are combinational from the current inputs, the state and the scoreboard. Only the state and the scoreboard are registered.
- A producer issued in cycle t makes its dependent instruction issue no earlier than cycle t+BUBBLES+1.
- A pair split because of an intra-pair dependency on an ALU result issues its second lane in cycle t+1 (zero bubble beyond the split).
- On reset:
  - State is `PAIR` and all counters are 0.
  - With valids low, `issue1_o`, `issue2_o` and `stall_o` are 0.
  - Asserting `rst` mid-`SECOND` abandons the pending lane immediately.

## Structure
- Package `issue_pkg` holds:
  - the class codes `CLS_ALU`, `CLS_MEM`, `CLS_MUL`, `CLS_BR`;
  - the state encoding `ST_PAIR`, `ST_SECOND`;
  - the default bubble constants.
- Sub-module `issue_scoreboard`:
  - Holds the 32×2-bit counters.
  - Two set ports (lane 1, lane 2), each with enable, address and value.
  - Four hazard query ports.
  - Clocked by `clk`, with asynchronous reset `rst`.
- The top level contains the FSM and the pair logic.

## Test plan
1. **Independent pair.** `add.w r1,r2,r3` paired with `add.w r4,r5,r6`, both ALU -> `issue1_o`=`issue2_o`=1 and `stall_o`=0 in the same cycle.
2. **Intra-pair RAW.** Lane 1 dest r4, lane 2 src1 r4 -> cycle 0: `issue1_o`=1, `stall_o`=1. Cycle 1 (`SECOND`): `issue2_o`=1, `stall_o`=0.
3. **Load-use (`LOAD_BUBBLES`=1).** Load to r5 issued in cycle 0; the next packet has lane 1 reading r5 -> cycle 1: `stall_o`=1, no issue. Cycle 2: `issue1_o`=1.
4. **Structural splits.** Two MEM lanes -> split over two cycles. mul.w r7 followed by a consumer of r7 (`MUL_BUBBLES`=2) -> consumer issues 3 cycles later.
5. **Flush in `SECOND`.** `ex_flush`=1 while in `SECOND` -> all outputs 0 that cycle, state is `PAIR` next cycle. Pending scoreboard counts continue decrementing to 0.
6. **Reset and r0.** `rst` pulsed with count[5]=2 while in `SECOND` -> count[5]=0, state `PAIR`, all outputs 0. A load with dest r0 followed by a reader of r0 -> no stall.

Source files
------------

// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared class codes, FSM states and bubble defaults for the issue controller
package issue_pkg;

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_MEM = 2'd1;
    localparam logic [1:0] CLS_MUL = 2'd2;
    localparam logic [1:0] CLS_BR  = 2'd3;

    typedef enum logic {
        ST_PAIR   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    localparam int DEF_LOAD_BUBBLES = 1;
    localparam int DEF_MUL_BUBBLES  = 2;

    // Loads and multiplies are the only multi-cycle producers; ALU/BR results forward.
    function automatic logic is_producer(input logic [1:0] cls, input logic gr_we);
        return (cls == CLS_MEM && gr_we) || (cls == CLS_MUL);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - per-register bubble counters with two set ports and four hazard queries
module issue_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       set1_en_i,
    input  logic [4:0] set1_addr_i,
    input  logic [1:0] set1_val_i,
    input  logic       set2_en_i,
    input  logic [4:0] set2_addr_i,
    input  logic [1:0] set2_val_i,
    input  logic [4:0] q0_addr_i,
    input  logic [4:0] q1_addr_i,
    input  logic [4:0] q2_addr_i,
    input  logic [4:0] q3_addr_i,
    output logic       q0_hz_o,
    output logic       q1_hz_o,
    output logic       q2_hz_o,
    output logic       q3_hz_o
);

    logic [1:0] cnt_q [32];
    logic [1:0] cnt_d [32];

    // A fresh producer overrides the decrement; lane 2 is younger so its set is applied last.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = (cnt_q[i] != 2'd0) ? cnt_q[i] - 2'd1 : 2'd0;
            if (i != 0) begin
                if (set1_en_i && set1_addr_i == 5'(i)) cnt_d[i] = set1_val_i;
                if (set2_en_i && set2_addr_i == 5'(i)) cnt_d[i] = set2_val_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign q0_hz_o = (q0_addr_i != 5'd0) && (cnt_q[q0_addr_i] != 2'd0);
    assign q1_hz_o = (q1_addr_i != 5'd0) && (cnt_q[q1_addr_i] != 2'd0);
    assign q2_hz_o = (q2_addr_i != 5'd0) && (cnt_q[q2_addr_i] != 2'd0);
    assign q3_hz_o = (q3_addr_i != 5'd0) && (cnt_q[q3_addr_i] != 2'd0);

endmodule

// File: rtl/dual_issue_ctrl.sv
// rtl/dual_issue_ctrl.sv - dual-issue decode controller: pair/split FSM and scoreboard-driven stalls
module dual_issue_ctrl
    import issue_pkg::*;
#(
    parameter int LOAD_BUBBLES = DEF_LOAD_BUBBLES,
    parameter int MUL_BUBBLES  = DEF_MUL_BUBBLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in1_valid,
    input  logic       in2_valid,
    input  logic [4:0] in1_src1,
    input  logic [4:0] in1_src2,
    input  logic [4:0] in2_src1,
    input  logic [4:0] in2_src2,
    input  logic [4:0] in1_dest,
    input  logic [4:0] in2_dest,
    input  logic       in1_gr_we,
    input  logic       in2_gr_we,
    input  logic [1:0] in1_class,
    input  logic [1:0] in2_class,
    input  logic       ex_flush,
    output logic       issue1_o,
    output logic       issue2_o,
    output logic       stall_o
);

    localparam logic [1:0] LOAD_CNT = 2'(LOAD_BUBBLES);
    localparam logic [1:0] MUL_CNT  = 2'(MUL_BUBBLES);

    state_e state_q, state_d;
    logic   hz_11, hz_12, hz_21, hz_22;
    logic   hz1, hz2, raw12, pairable;

    issue_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set1_en_i  (issue1_o && is_producer(in1_class, in1_gr_we)),
        .set1_addr_i(in1_dest),
        .set1_val_i ((in1_class == CLS_MUL) ? MUL_CNT : LOAD_CNT),
        .set2_en_i  (issue2_o && is_producer(in2_class, in2_gr_we)),
        .set2_addr_i(in2_dest),
        .set2_val_i ((in2_class == CLS_MUL) ? MUL_CNT : LOAD_CNT),
        .q0_addr_i  (in1_src1),
        .q1_addr_i  (in1_src2),
        .q2_addr_i  (in2_src1),
        .q3_addr_i  (in2_src2),
        .q0_hz_o    (hz_11),
        .q1_hz_o    (hz_12),
        .q2_hz_o    (hz_21),
        .q3_hz_o    (hz_22)
    );

    assign hz1   = hz_11 | hz_12;
    assign hz2   = hz_21 | hz_22;
    assign raw12 = in1_gr_we && (in1_dest != 5'd0) &&
                   ((in2_src1 == in1_dest) || (in2_src2 == in1_dest));

    assign pairable = !hz2 && !raw12 &&
                      !(in1_class == CLS_MEM && in2_class == CLS_MEM) &&
                      !(in1_class == CLS_MUL && in2_class == CLS_MUL) &&
                      (in1_class != CLS_BR);

    always_comb begin
        issue1_o = 1'b0;
        issue2_o = 1'b0;
        stall_o  = 1'b0;
        state_d  = state_q;
        if (ex_flush) begin
            state_d = ST_PAIR;
        end else begin
            case (state_q)
                ST_PAIR: begin
                    if (in1_valid) begin
                        if (hz1) begin
                            stall_o = 1'b1;
                        end else if (!in2_valid || pairable) begin
                            issue1_o = 1'b1;
                            issue2_o = in2_valid;
                        end else begin
                            issue1_o = 1'b1;
                            stall_o  = 1'b1;
                            state_d  = ST_SECOND;
                        end
                    end else begin
                        issue2_o = in2_valid & !hz2;
                        stall_o  = in2_valid & hz2;
                    end
                end
                ST_SECOND: begin
                    if (!hz2) begin
                        issue2_o = 1'b1;
                        state_d  = ST_PAIR;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                default: state_d = ST_PAIR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_PAIR;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb/tb_dual_issue_ctrl.sv - directed table, corner sequences and randomized model check for dual_issue_ctrl
module tb_dual_issue_ctrl;
    import issue_pkg::*;

    localparam int LB = 1;
    localparam int MB = 2;

    typedef struct {
        logic       v1, v2, we1, we2, fl;
        logic [1:0] c1, c2;
        logic [4:0] d1, s11, s12, d2, s21, s22;
        logic       e1, e2, es;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in1_valid, in2_valid, in1_gr_we, in2_gr_we, ex_flush;
    logic [4:0] in1_src1, in1_src2, in2_src1, in2_src2, in1_dest, in2_dest;
    logic [1:0] in1_class, in2_class;
    logic       issue1_o, issue2_o, stall_o;

    int checks = 0;
    int failures = 0;

    // Reference model: the cycle index at which each register's value becomes usable.
    int  cyc = 0;
    int  ready_at [32];
    bit  m_second = 0;

    always #5 clk = ~clk;

    dual_issue_ctrl #(.LOAD_BUBBLES(LB), .MUL_BUBBLES(MB)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in2_valid(in2_valid),
        .in1_src1(in1_src1), .in1_src2(in1_src2),
        .in2_src1(in2_src1), .in2_src2(in2_src2),
        .in1_dest(in1_dest), .in2_dest(in2_dest),
        .in1_gr_we(in1_gr_we), .in2_gr_we(in2_gr_we),
        .in1_class(in1_class), .in2_class(in2_class),
        .ex_flush(ex_flush),
        .issue1_o(issue1_o), .issue2_o(issue2_o), .stall_o(stall_o)
    );

    function automatic vec_t mk(
        input logic v1, input logic [1:0] c1, input logic [4:0] d1, input logic we1,
        input logic [4:0] s11, input logic [4:0] s12,
        input logic v2, input logic [1:0] c2, input logic [4:0] d2, input logic we2,
        input logic [4:0] s21, input logic [4:0] s22,
        input logic fl, input logic e1, input logic e2, input logic es);
        vec_t v;
        v.v1 = v1; v.c1 = c1; v.d1 = d1; v.we1 = we1; v.s11 = s11; v.s12 = s12;
        v.v2 = v2; v.c2 = c2; v.d2 = d2; v.we2 = we2; v.s21 = s21; v.s22 = s22;
        v.fl = fl; v.e1 = e1; v.e2 = e2; v.es = es;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in1_valid = v.v1; in1_class = v.c1; in1_dest = v.d1; in1_gr_we = v.we1;
        in1_src1 = v.s11; in1_src2 = v.s12;
        in2_valid = v.v2; in2_class = v.c2; in2_dest = v.d2; in2_gr_we = v.we2;
        in2_src1 = v.s21; in2_src2 = v.s22;
        ex_flush = v.fl;
    endtask

    task automatic compare(input vec_t v, input string nm);
        checks++;
        if ({issue1_o, issue2_o, stall_o} !== {v.e1, v.e2, v.es}) begin
            failures++;
            $display("FAIL %s: got issue1=%0b issue2=%0b stall=%0b, want issue1=%0b issue2=%0b stall=%0b",
                     nm, issue1_o, issue2_o, stall_o, v.e1, v.e2, v.es);
        end
    endtask

    // Drives one cycle's inputs away from the rising edge and checks the combinational outputs.
    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        drive(v);
        #1;
        compare(v, nm);
    endtask

    function automatic bit m_hz(input logic [4:0] r);
        return (r != 5'd0) && (cyc < ready_at[r]);
    endfunction

    function automatic vec_t model_expect(input vec_t v);
        vec_t e = v;
        bit h1 = m_hz(v.s11) || m_hz(v.s12);
        bit h2 = m_hz(v.s21) || m_hz(v.s22);
        bit dep = v.we1 && v.d1 != 0 && (v.s21 == v.d1 || v.s22 == v.d1);
        bit pair = !h2 && !dep && !(v.c1 == CLS_MEM && v.c2 == CLS_MEM) &&
                   !(v.c1 == CLS_MUL && v.c2 == CLS_MUL) && v.c1 != CLS_BR;
        e.e1 = 0; e.e2 = 0; e.es = 0;
        if (v.fl) begin
        end else if (m_second) begin
            e.e2 = !h2; e.es = h2;
        end else if (v.v1) begin
            if (h1) e.es = 1;
            else begin
                e.e1 = 1;
                e.e2 = v.v2 && pair;
                e.es = v.v2 && !pair;
            end
        end else begin
            e.e2 = v.v2 && !h2; e.es = v.v2 && h2;
        end
        return e;
    endfunction

    task automatic model_advance(input vec_t e);
        if (e.e1 && (e.c1 == CLS_MUL || (e.c1 == CLS_MEM && e.we1)) && e.d1 != 0)
            ready_at[e.d1] = cyc + ((e.c1 == CLS_MUL) ? MB : LB) + 1;
        if (e.e2 && (e.c2 == CLS_MUL || (e.c2 == CLS_MEM && e.we2)) && e.d2 != 0)
            ready_at[e.d2] = cyc + ((e.c2 == CLS_MUL) ? MB : LB) + 1;
        if (e.fl) m_second = 0;
        else if (!m_second && e.e1 && e.es) m_second = 1;
        else if (m_second && e.e2) m_second = 0;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        m_second = 0;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.v1 = ($urandom_range(0, 3) != 0); v.v2 = ($urandom_range(0, 3) != 0);
        v.c1 = 2'($urandom_range(0, 3));     v.c2 = 2'($urandom_range(0, 3));
        v.we1 = 1'($urandom_range(0, 1));    v.we2 = 1'($urandom_range(0, 1));
        v.d1 = 5'($urandom_range(0, 7));     v.d2 = 5'($urandom_range(0, 7));
        v.s11 = 5'($urandom_range(0, 7));    v.s12 = 5'($urandom_range(0, 7));
        v.s21 = 5'($urandom_range(0, 7));    v.s22 = 5'($urandom_range(0, 7));
        v.fl = ($urandom_range(0, 15) == 0);
        v.e1 = 0; v.e2 = 0; v.es = 0;
        return v;
    endfunction

    vec_t tbl [$];
    vec_t z, v, e;

    initial begin
        z = mk(0, CLS_ALU, 0, 0, 0, 0, 0, CLS_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        compare(z, "reset_idle");
        @(negedge clk);
        rst = 1'b0;

        // Each row is one cycle; state carries from row to row.
        tbl.push_back(mk(0, CLS_ALU, 0, 0, 0, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, CLS_ALU, 1, 1, 2, 3,   1, CLS_ALU, 4, 1, 5, 6,   0, 1, 1, 0));
        tbl.push_back(mk(1, CLS_ALU, 4, 1, 2, 3,   1, CLS_ALU, 7, 1, 4, 0,   0, 1, 0, 1));
        tbl.push_back(mk(1, CLS_ALU, 4, 1, 2, 3,   1, CLS_ALU, 7, 1, 4, 0,   0, 0, 1, 0));
        tbl.push_back(mk(1, CLS_MEM, 5, 1, 1, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, CLS_ALU, 8, 1, 5, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, CLS_ALU, 8, 1, 5, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, CLS_MEM, 9, 1, 1, 0,   1, CLS_MEM, 0, 0, 2, 3,   0, 1, 0, 1));
        tbl.push_back(mk(1, CLS_MEM, 9, 1, 1, 0,   1, CLS_MEM, 0, 0, 2, 3,   0, 0, 1, 0));
        tbl.push_back(mk(1, CLS_MUL, 7, 1, 1, 2,   0, CLS_ALU, 0, 0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, CLS_ALU, 3, 1, 7, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, CLS_ALU, 3, 1, 7, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 0, 0, 1));
        tbl.push_back(mk(1, CLS_ALU, 3, 1, 7, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, CLS_BR,  0, 0, 1, 2,   1, CLS_ALU, 6, 1, 1, 2,   0, 1, 0, 1));
        tbl.push_back(mk(1, CLS_BR,  0, 0, 1, 2,   1, CLS_ALU, 6, 1, 1, 2,   0, 0, 1, 0));
        tbl.push_back(mk(0, CLS_ALU, 0, 0, 0, 0,   1, CLS_ALU, 6, 1, 1, 2,   0, 0, 1, 0));
        tbl.push_back(mk(1, CLS_MEM, 0, 1, 1, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, CLS_ALU, 2, 1, 0, 0,   0, CLS_ALU, 0, 0, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, CLS_MUL, 10, 1, 1, 2,  1, CLS_MUL, 11, 1, 1, 2,  0, 1, 0, 1));
        tbl.push_back(mk(1, CLS_MUL, 10, 1, 1, 2,  1, CLS_MUL, 11, 1, 1, 2,  0, 0, 1, 0));
        tbl.push_back(mk(0, CLS_ALU, 0, 0, 0, 0,   1, CLS_ALU, 12, 1, 10, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, CLS_ALU, 0, 0, 0, 0,   1, CLS_ALU, 12, 1, 10, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, CLS_ALU, 1, 1, 2, 3,   1, CLS_ALU, 12, 1, 11, 0, 0, 1, 1, 0));
        foreach (tbl[i]) step(tbl[i], $sformatf("table_row%0d", i));

        // Flush while SECOND: outputs die, state returns to PAIR, r5 count keeps draining.
        do_reset();
        step(mk(1, CLS_MUL, 5, 1, 1, 0, 1, CLS_ALU, 6, 1, 5, 0, 0, 1, 0, 1), "flush_split");
        step(mk(1, CLS_MUL, 5, 1, 1, 0, 1, CLS_ALU, 6, 1, 5, 0, 1, 0, 0, 0), "flush_outputs");
        step(mk(1, CLS_ALU, 8, 1, 5, 0, 1, CLS_ALU, 9, 1, 1, 2, 0, 0, 0, 1), "flush_pair_count");
        step(mk(1, CLS_ALU, 8, 1, 5, 0, 1, CLS_ALU, 9, 1, 1, 2, 0, 1, 1, 0), "flush_drained");

        // Asynchronous reset while SECOND with count[5]=2.
        step(mk(1, CLS_MUL, 5, 1, 1, 0, 1, CLS_ALU, 6, 1, 5, 0, 0, 1, 0, 1), "rst_split");
        @(negedge clk);
        drive(z);
        rst = 1'b1;
        #1;
        compare(z, "rst_outputs");
        #2;
        rst = 1'b0;
        step(mk(1, CLS_ALU, 8, 1, 5, 0, 1, CLS_ALU, 9, 1, 1, 2, 0, 1, 1, 0), "rst_cleared");

        // Randomized run against the ready-cycle model; stalled packets are held.
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        m_second = 0;
        e = z;
        for (int n = 0; n < 600; n++) begin
            if (e.es && !e.fl) begin
                v = e;
                v.fl = ($urandom_range(0, 15) == 0);
            end else begin
                v = rand_vec();
            end
            e = model_expect(v);
            step(e, $sformatf("random_cycle%0d", n));
            model_advance(e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
